// File: rtl/motion_pkg.sv
// Shared types and constants for the motion-detect front end.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int MOTION_DATA_WIDTH = 32;
  localparam int BMP_HEADER_BYTES  = 54;

  // 720x540 RGB image, three bytes per pixel, four bytes per packed word.
  localparam int DEFAULT_WORDS_PER_FRAME = (720 * 540 * 3) / 4;

endpackage

// File: rtl/motion_frame_sequencer_if.sv
// Stream inputs, FIFO write ports and the output-FIFO read strobe of the
// frame sequencer. master = sequencer side, slave = surrounding datapath.
interface motion_frame_sequencer_if
  import motion_pkg::*;
#(
  parameter int DATA_WIDTH = MOTION_DATA_WIDTH
);

  logic                  bg_valid;
  logic [DATA_WIDTH-1:0] bg_data;
  logic                  bg_ready;
  logic                  fr_valid;
  logic [DATA_WIDTH-1:0] fr_data;
  logic                  fr_ready;

  logic                  bg_fifo_wr_en;
  logic [DATA_WIDTH-1:0] bg_fifo_din;
  logic                  fr_fifo_wr_en;
  logic [DATA_WIDTH-1:0] fr_fifo_din;
  logic                  fr_hl_fifo_wr_en;
  logic [DATA_WIDTH-1:0] fr_hl_fifo_din;

  logic                  bg_fifo_full;
  logic                  fr_fifo_full;
  logic                  fr_hl_fifo_full;

  logic                  highlight_fifo_rd_en;

  modport master (
    input  bg_valid, bg_data, fr_valid, fr_data,
    output bg_ready, fr_ready,
    output bg_fifo_wr_en, bg_fifo_din,
    output fr_fifo_wr_en, fr_fifo_din,
    output fr_hl_fifo_wr_en, fr_hl_fifo_din,
    input  bg_fifo_full, fr_fifo_full, fr_hl_fifo_full,
    input  highlight_fifo_rd_en
  );

  modport slave (
    output bg_valid, bg_data, fr_valid, fr_data,
    input  bg_ready, fr_ready,
    input  bg_fifo_wr_en, bg_fifo_din,
    input  fr_fifo_wr_en, fr_fifo_din,
    input  fr_hl_fifo_wr_en, fr_hl_fifo_din,
    output bg_fifo_full, fr_fifo_full, fr_hl_fifo_full,
    output highlight_fifo_rd_en
  );

endinterface

// File: rtl/motion_frame_sequencer_frame_word_counter.sv
// Saturating word counter with synchronous clear; o_hit flags the limit.
module frame_word_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_hit
);

  logic [WIDTH-1:0] r_count;

  // Count up until the limit, then hold; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_hit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_hit   = (r_count == WIDTH'(LIMIT));

endmodule

// File: rtl/motion_frame_sequencer.sv
// Frame sequencer: joins the background and pedestrian streams, writes them
// in lockstep into the three input FIFOs and tracks output-FIFO draining.
//
// state  | meaning
// IDLE   | waiting for start; read strobes ignored
// STREAM | accepting paired words until a full frame has been written
// DRAIN  | all input written; waiting for the last output word to be read
// DONE   | one-cycle frame_done; cont picks next frame or IDLE
module motion_frame_sequencer
  import motion_pkg::*;
#(
  parameter int DATA_WIDTH      = MOTION_DATA_WIDTH,
  parameter int WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME,
  parameter int CNT_WIDTH       = $clog2(WORDS_PER_FRAME + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cont,
  motion_frame_sequencer_if.master       bus,
  output logic                           busy,
  output logic                           frame_done,
  output logic [15:0]                    frame_count,
  output logic                           overrun_err
);

  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(WORDS_PER_FRAME - 1);

  seq_state_t          r_state;
  logic                r_frame_done;
  logic [15:0]         r_frame_count;
  logic                r_overrun;

  logic                w_can_acc;
  logic                w_xfer;
  logic                w_seq_clr;
  logic                w_out_active;
  logic                w_out_inc;
  logic                w_in_last;
  logic                w_out_complete;
  logic                w_overrun;
  logic [CNT_WIDTH-1:0] w_in_cnt;
  logic [CNT_WIDTH-1:0] w_out_cnt;
  logic                w_in_hit;
  logic                w_out_hit;

  // Any full flag stalls all three writes so the FIFOs stay word-aligned;
  // the in-count guard keeps a frame from ever exceeding its word budget.
  assign w_can_acc = (r_state == STREAM) && !w_in_hit &&
                     !bus.bg_fifo_full && !bus.fr_fifo_full && !bus.fr_hl_fifo_full;
  assign w_xfer    = w_can_acc && bus.bg_valid && bus.fr_valid;

  // Each ready only depends on the other stream's valid, so neither side
  // can complete a handshake without its partner.
  assign bus.bg_ready = w_can_acc && bus.fr_valid;
  assign bus.fr_ready = w_can_acc && bus.bg_valid;

  assign bus.bg_fifo_wr_en    = w_xfer;
  assign bus.fr_fifo_wr_en    = w_xfer;
  assign bus.fr_hl_fifo_wr_en = w_xfer;
  assign bus.bg_fifo_din      = w_xfer ? bus.bg_data : ZERO_WORD;
  assign bus.fr_fifo_din      = w_xfer ? bus.fr_data : ZERO_WORD;
  assign bus.fr_hl_fifo_din   = w_xfer ? bus.fr_data : ZERO_WORD;

  assign w_seq_clr    = ((r_state == IDLE) && start) || ((r_state == DONE) && cont);
  assign w_out_active = (r_state == STREAM) || (r_state == DRAIN);
  assign w_out_inc    = bus.highlight_fifo_rd_en && w_out_active;
  assign w_in_last    = w_xfer && (w_in_cnt == LAST_IDX);

  // Completion looks at the registered count plus a strobe landing this
  // cycle, so frame_done follows the final read by exactly one cycle.
  assign w_out_complete = w_out_hit || (w_out_inc && (w_out_cnt == LAST_IDX));

  // A read with the output count already saturated is a word the frame
  // never produced; DONE still belongs to the finished frame.
  assign w_overrun = bus.highlight_fifo_rd_en && w_out_hit && (r_state != IDLE);

  frame_word_counter #(
    .WIDTH (CNT_WIDTH),
    .LIMIT (WORDS_PER_FRAME)
  ) u_in_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_seq_clr),
    .i_inc   (w_xfer),
    .o_count (w_in_cnt),
    .o_hit   (w_in_hit)
  );

  frame_word_counter #(
    .WIDTH (CNT_WIDTH),
    .LIMIT (WORDS_PER_FRAME)
  ) u_out_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_seq_clr),
    .i_inc   (w_out_inc),
    .o_count (w_out_cnt),
    .o_hit   (w_out_hit)
  );

  // Sequencer state plus its registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_overrun) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= STREAM;
            r_overrun <= 1'b0;
          end
        end
        STREAM: begin
          if (w_in_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_complete) begin
            r_state       <= DONE;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        DONE: begin
          r_state <= cont ? STREAM : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign overrun_err = r_overrun;

endmodule

// File: tb/tb_motion_frame_sequencer.sv
// Directed bench for motion_frame_sequencer with an 8-word frame.
module tb_motion_frame_sequencer;
  import motion_pkg::*;

  localparam int WPF = 8;
  localparam int DW  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overrun_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] q_bg[$];
  logic [31:0] q_fr[$];
  logic [31:0] q_hl[$];

  motion_frame_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  motion_frame_sequencer #(
    .DATA_WIDTH      (DW),
    .WORDS_PER_FRAME (WPF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cont        (cont),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Capture every FIFO write as the external FIFOs would see it.
  always @(posedge clk) begin
    if (bus.bg_fifo_wr_en)    q_bg.push_back(bus.bg_fifo_din);
    if (bus.fr_fifo_wr_en)    q_fr.push_back(bus.fr_fifo_din);
    if (bus.fr_hl_fifo_wr_en) q_hl.push_back(bus.fr_hl_fifo_din);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [31:0] bg_word(input int i);
    return 32'(i);
  endfunction

  function automatic logic [31:0] fr_word(input int i);
    return 32'h100 + 32'(i);
  endfunction

  function automatic logic [31:0] wr_bits();
    return {29'b0, bus.bg_fifo_wr_en, bus.fr_fifo_wr_en, bus.fr_hl_fifo_wr_en};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input seq_state_t exp);
    check(tag, 32'(dut.r_state), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_bg.delete();
    q_fr.delete();
    q_hl.delete();
  endtask

  task automatic set_streams(input logic v, input int idx);
    bus.bg_valid = v;
    bus.fr_valid = v;
    bus.bg_data  = bg_word(idx);
    bus.fr_data  = fr_word(idx);
  endtask

  // One paired word per cycle, each expected to be written immediately.
  task automatic stream_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      set_streams(1'b1, first + i);
      #1;
      check("xfer_wr_en", wr_bits(), 32'h7);
      check("xfer_bg_din", bus.bg_fifo_din, bg_word(first + i));
      check("xfer_hl_din", bus.fr_hl_fifo_din, fr_word(first + i));
      tick();
    end
    set_streams(1'b0, 0);
  endtask

  task automatic finish_frame();
    bus.highlight_fifo_rd_en = 1'b1;
    repeat (WPF - 1) tick();
    check("done_early", 32'(frame_done), 32'd0);
    tick();
    bus.highlight_fifo_rd_en = 1'b0;
    check("done_pulse", 32'(frame_done), 32'd1);
    tick();
    check("done_once", 32'(frame_done), 32'd0);
    check_state("idle_after_done", IDLE);
  endtask

  task automatic check_fifos(input int n);
    check("q_bg_size", 32'(q_bg.size()), 32'(n));
    check("q_fr_size", 32'(q_fr.size()), 32'(n));
    check("q_hl_size", 32'(q_hl.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check("q_bg_word", q_bg[i], bg_word(i + 1));
      check("q_fr_word", q_fr[i], fr_word(i + 1));
      check("q_hl_word", q_hl[i], fr_word(i + 1));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_overrun", 32'(overrun_err), 32'd0);
    check("rst_ready", {30'b0, bus.bg_ready, bus.fr_ready}, 32'd0);
    check("rst_wr_en", wr_bits(), 32'd0);
    check("rst_bg_din", bus.bg_fifo_din, 32'd0);
    check("rst_fr_din", bus.fr_fifo_din, 32'd0);
    check("rst_hl_din", bus.fr_hl_fifo_din, 32'd0);
    check_state("rst_state", IDLE);
  endtask

  initial begin
    bus.bg_fifo_full         = 1'b0;
    bus.fr_fifo_full         = 1'b0;
    bus.fr_hl_fifo_full      = 1'b0;
    bus.highlight_fifo_rd_en = 1'b0;
    set_streams(1'b1, 5);

    // Reset with live streams: nothing may leak through.
    reset = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    set_streams(1'b0, 0);
    reset = 1'b1;
    tick();

    // Basic frame.
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s1_busy", 32'(busy), 32'd1);
    check_state("s1_stream", STREAM);
    stream_words(1, WPF);
    check_state("s1_drain", DRAIN);
    set_streams(1'b1, 9);
    #1;
    check("s1_no_extra_wr", wr_bits(), 32'd0);
    check("s1_no_ready", {30'b0, bus.bg_ready, bus.fr_ready}, 32'd0);
    set_streams(1'b0, 0);
    finish_frame();
    check("s1_count", 32'(frame_count), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check_fifos(WPF);

    // Skewed streams: pedestrian valid lags by three cycles.
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.bg_valid = 1'b1;
    bus.bg_data  = bg_word(1);
    bus.fr_valid = 1'b0;
    repeat (3) begin
      #1;
      check("s2_bg_ready", 32'(bus.bg_ready), 32'd0);
      check("s2_fr_ready", 32'(bus.fr_ready), 32'd1);
      check("s2_no_wr", wr_bits(), 32'd0);
      tick();
    end
    stream_words(1, WPF);
    finish_frame();
    check("s2_count", 32'(frame_count), 32'd2);
    check_fifos(WPF);

    // Backpressure: highlight FIFO full in streaming cycles 3..6.
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int w;
      w = 1;
      for (int c = 1; c <= 12; c++) begin
        set_streams(1'b1, w);
        bus.fr_hl_fifo_full = (c >= 3 && c <= 6);
        #1;
        if (c >= 3 && c <= 6) begin
          check("s3_stall_wr", wr_bits(), 32'd0);
          check("s3_stall_ready", {30'b0, bus.bg_ready, bus.fr_ready}, 32'd0);
        end else begin
          check("s3_wr", wr_bits(), 32'h7);
          w++;
        end
        tick();
      end
    end
    bus.fr_hl_fifo_full = 1'b0;
    set_streams(1'b0, 0);
    check_state("s3_drain", DRAIN);
    finish_frame();
    check("s3_count", 32'(frame_count), 32'd3);
    check_fifos(WPF);

    // Continuous mode, three back-to-back frames from a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("s4_count_reset", 32'(frame_count), 32'd0);
    cont  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      clear_q();
      stream_words(1, WPF);
      bus.highlight_fifo_rd_en = 1'b1;
      repeat (WPF) tick();
      bus.highlight_fifo_rd_en = 1'b0;
      check("s4_done", 32'(frame_done), 32'd1);
      check("s4_count", 32'(frame_count), 32'(f));
      check_state("s4_state_done", DONE);
      check_fifos(WPF);
      if (f == 3) cont = 1'b0;
      set_streams(1'b1, 1);
      #1;
      check("s4_done_no_wr", wr_bits(), 32'd0);
      tick();
      check("s4_busy_after_done", 32'(busy), (f < 3) ? 32'd1 : 32'd0);
    end
    set_streams(1'b0, 0);
    cont = 1'b0;

    // Overrun: nine read strobes against an 8-word frame.
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    stream_words(1, WPF - 1);
    bus.highlight_fifo_rd_en = 1'b1;
    repeat (WPF) tick();
    check("s5_no_overrun_yet", 32'(overrun_err), 32'd0);
    tick();
    bus.highlight_fifo_rd_en = 1'b0;
    check("s5_overrun", 32'(overrun_err), 32'd1);
    check("s5_out_cnt_sat", 32'(dut.u_out_cnt.o_count), 32'd8);
    check_state("s5_still_stream", STREAM);
    stream_words(WPF, 1);
    check_state("s5_drain", DRAIN);
    check("s5_done_wait", 32'(frame_done), 32'd0);
    tick();
    check("s5_done_pulse", 32'(frame_done), 32'd1);
    check("s5_count", 32'(frame_count), 32'd4);
    tick();
    check("s5_done_once", 32'(frame_done), 32'd0);
    check("s5_overrun_sticky", 32'(overrun_err), 32'd1);
    check_fifos(WPF);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s5_overrun_cleared", 32'(overrun_err), 32'd0);
    check("s5_busy_restart", 32'(busy), 32'd1);

    // Mid-frame reset after four words, then a clean frame.
    stream_words(1, 4);
    set_streams(1'b1, 5);
    reset = 1'b0;
    tick();
    check_reset_outputs();
    reset = 1'b1;
    set_streams(1'b0, 0);
    tick();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    stream_words(1, WPF);
    finish_frame();
    check("s6_count", 32'(frame_count), 32'd1);
    check_fifos(WPF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
